bsg_mesh_router_output_sched: RTL and testbench



---
 rtl/bsg_mesh_router_output_sched_if.sv | 27 ++
 rtl/bsg_mesh_router_output_sched.sv | 119 +++++++++++
 tb/tb_bsg_mesh_router_output_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bsg_mesh_router_output_sched_if.sv
// Request/grant/credit bundle between the crossbar inputs and one output-port scheduler.
interface bsg_mesh_router_output_sched_if #(
  parameter int els_p           = 5,
  parameter int len_width_p     = 4,
  parameter int credits_p       = 4,
  parameter int credit_width_lp = $clog2(credits_p+1)
);
  logic [els_p-1:0]             reqs_i;
  logic [els_p*len_width_p-1:0] hdr_len_i;
  logic                         credit_return_i;
  logic                         v_o;
  logic [els_p-1:0]             sel_one_hot_o;
  logic [els_p-1:0]             yumi_o;
  logic                         locked_o;
  logic [credit_width_lp-1:0]   credits_o;
  logic                         error_o;

  modport master (
    output reqs_i, hdr_len_i, credit_return_i,
    input  v_o, sel_one_hot_o, yumi_o, locked_o, credits_o, error_o
  );

  modport slave (
    input  reqs_i, hdr_len_i, credit_return_i,
    output v_o, sel_one_hot_o, yumi_o, locked_o, credits_o, error_o
  );
endinterface

// File: rtl/bsg_mesh_router_output_sched.sv
// Round-robin wormhole scheduler for one router output; grant is same-cycle (0 latency),
// state updates next edge. Sends only while downstream credits remain; lock held through stalls.
module bsg_mesh_router_output_sched #(
  parameter int els_p           = 5,
  parameter int len_width_p     = 4,
  parameter int credits_p       = 4,
  parameter int credit_width_lp = $clog2(credits_p+1)
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_mesh_router_output_sched_if.slave bus
);
  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                     state_r, state_n;
  logic [lg_els_lp-1:0]       ptr_r, ptr_n;
  logic [lg_els_lp-1:0]       owner_r, owner_n;
  logic [len_width_p-1:0]     remaining_r, remaining_n;
  logic [credit_width_lp-1:0] credits_r, credits_n;
  logic                       error_r, error_n;

  logic                       cand_vld;
  logic [lg_els_lp-1:0]       cand;
  logic [lg_els_lp-1:0]       cand_inc;
  logic [len_width_p-1:0]     cand_len;
  logic                       send;
  logic [els_p-1:0]           sel;
  int                         j;

  always_comb begin
    cand_vld    = 1'b0;
    cand        = '0;
    j           = 0;
    state_n     = state_r;
    ptr_n       = ptr_r;
    owner_n     = owner_r;
    remaining_n = remaining_r;
    credits_n   = credits_r;
    error_n     = error_r;
    sel         = '0;

    if (state_r == IDLE) begin
      // Scan upward from the pointer with wrap; first requester wins.
      for (int i = 0; i < els_p; i++) begin
        j = int'(ptr_r) + i;
        if (j >= els_p) j = j - els_p;
        if (!cand_vld && bus.reqs_i[j]) begin
          cand_vld = 1'b1;
          cand     = lg_els_lp'(j);
        end
      end
    end else begin
      cand_vld = bus.reqs_i[owner_r];
      cand     = owner_r;
    end

    send     = cand_vld && (credits_r != '0);
    cand_inc = (int'(cand) == els_p-1) ? '0 : cand + lg_els_lp'(1);
    cand_len = bus.hdr_len_i[cand*len_width_p +: len_width_p];
    if (send) sel[cand] = 1'b1;

    if (send && (state_r == IDLE)) begin
      if (cand_len == '0) begin
        ptr_n = cand_inc;
      end else begin
        state_n     = LOCKED;
        owner_n     = cand;
        remaining_n = cand_len;
      end
    end else if (send) begin
      remaining_n = remaining_r - len_width_p'(1);
      if (remaining_r == len_width_p'(1)) begin
        state_n = IDLE;
        ptr_n   = cand_inc;
      end
    end

    // A send and a return in the same cycle cancel out.
    if (send && !bus.credit_return_i) begin
      credits_n = credits_r - credit_width_lp'(1);
    end else if (!send && bus.credit_return_i) begin
      if (credits_r == credit_width_lp'(credits_p)) error_n = 1'b1;
      else                                          credits_n = credits_r + credit_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      owner_r     <= '0;
      remaining_r <= '0;
      credits_r   <= credit_width_lp'(credits_p);
      error_r     <= 1'b0;
    end else begin
      state_r     <= state_n;
      ptr_r       <= ptr_n;
      owner_r     <= owner_n;
      remaining_r <= remaining_n;
      credits_r   <= credits_n;
      error_r     <= error_n;
    end
  end

  assign bus.v_o           = send && reset_n_i;
  assign bus.sel_one_hot_o = sel & {els_p{reset_n_i}};
  assign bus.yumi_o        = sel & {els_p{reset_n_i}};
  assign bus.locked_o      = (state_r == LOCKED) && reset_n_i;
  assign bus.credits_o     = credits_r;
  assign bus.error_o       = error_r;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) assert ($countones(bus.sel_one_hot_o) <= 1);
  end
`endif
endmodule

// File: tb/tb_bsg_mesh_router_output_sched.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor pops and compares.
module tb_bsg_mesh_router_output_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bsg_mesh_router_output_sched_if #(.els_p(5), .len_width_p(4), .credits_p(4)) bif ();

  bsg_mesh_router_output_sched #(.els_p(5), .len_width_p(4), .credits_p(4)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bif)
  );

  typedef struct {
    bit         v;
    logic [4:0] sel;
    bit         locked;
    int         cred;
    bit         err;
  } st_t;

  st_t        status_q[$];
  logic [4:0] grant_q[$];
  int total = 0;
  int bad = 0;

  // Reference model state
  bit m_locked = 0;
  int m_owner = 0, m_rem = 0, m_ptr = 0, m_cred = 4;
  bit m_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] r, input logic [19:0] l, input bit ret,
                       input bit rstn, input bit chk);
    st_t e;
    int  cand, len;
    bit  send;
    @(posedge clk); #1;
    bif.reqs_i = r;
    bif.hdr_len_i = l;
    bif.credit_return_i = ret;
    rst_n = rstn;

    cand = -1;
    if (rstn) begin
      if (m_locked) begin
        if (r[m_owner]) cand = m_owner;
      end else begin
        for (int k = 0; k < 5; k++)
          if (cand < 0 && r[(m_ptr + k) % 5]) cand = (m_ptr + k) % 5;
      end
    end
    send = (cand >= 0) && (m_cred > 0);
    e.v = send;
    e.sel = send ? 5'(1 << cand) : 5'd0;
    e.locked = rstn && m_locked;
    e.cred = m_cred;
    e.err = m_err;
    if (chk) begin
      status_q.push_back(e);
      if (send) grant_q.push_back(e.sel);
    end

    if (!rstn) begin
      m_locked = 0; m_owner = 0; m_rem = 0; m_ptr = 0; m_cred = 4; m_err = 0;
    end else begin
      if (send && !ret) m_cred--;
      else if (ret && !send) begin
        if (m_cred == 4) m_err = 1;
        else m_cred++;
      end
      if (send && !m_locked) begin
        len = int'((l >> (4 * cand)) & 20'hF);
        if (len == 0) m_ptr = (cand + 1) % 5;
        else begin
          m_locked = 1; m_owner = cand; m_rem = len;
        end
      end else if (send) begin
        m_rem--;
        if (m_rem == 0) begin
          m_locked = 0;
          m_ptr = (m_owner + 1) % 5;
        end
      end
    end
  endtask

  task automatic run(input int n, input logic [4:0] r, input logic [19:0] l, input bit ret);
    for (int i = 0; i < n; i++) drive(r, l, ret, 1'b1, 1'b1);
  endtask

  // Monitor: per-cycle status plus grant scoreboard on every presented flit.
  initial begin
    st_t e;
    logic [4:0] g;
    forever begin
      @(negedge clk);
      if (status_q.size() > 0) begin
        e = status_q.pop_front();
        check("v_o", bif.v_o, e.v);
        check("sel_one_hot_o", bif.sel_one_hot_o, e.sel);
        check("locked_o", bif.locked_o, e.locked);
        check("credits_o", bif.credits_o, e.cred);
        check("error_o", bif.error_o, e.err);
      end
      if (bif.v_o === 1'b1) begin
        if (grant_q.size() == 0) begin
          total++; bad++;
          $display("FAIL grant_extra: got sel %b expected no flit", bif.sel_one_hot_o);
        end else begin
          g = grant_q.pop_front();
          check("grant_sel", bif.sel_one_hot_o, g);
          check("grant_yumi", bif.yumi_o, g);
        end
      end
    end
  end

  initial begin
    bif.reqs_i = '0;
    bif.hdr_len_i = '0;
    bif.credit_return_i = 1'b0;
    drive(5'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    drive(5'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    run(2, 5'b00000, 20'h0, 1'b0);             // reset state

    run(6, 5'b11111, 20'h0, 1'b1);             // round robin single flit
    run(1, 5'b00010, 20'h0, 1'b1);
    run(6, 5'b00111, 20'h00300, 1'b1);         // wormhole on input 2

    drive(5'b0, 20'h0, 1'b0, 1'b0, 1'b1);
    run(7, 5'b00010, 20'h00070, 1'b0);         // credit exhaustion
    run(1, 5'b00010, 20'h00070, 1'b1);
    run(2, 5'b00010, 20'h00070, 1'b0);
    run(2, 5'b00000, 20'h0, 1'b1);
    run(1, 5'b00010, 20'h0, 1'b1);             // send + return together
    run(4, 5'b00000, 20'h0, 1'b1);             // overflow sets sticky error
    run(2, 5'b00000, 20'h0, 1'b0);

    drive(5'b0, 20'h0, 1'b0, 1'b0, 1'b1);
    run(2, 5'b01000, 20'h03000, 1'b1);         // owner bubble
    run(2, 5'b00001, 20'h0, 1'b1);
    run(4, 5'b01001, 20'h0, 1'b1);

    drive(5'b0, 20'h0, 1'b0, 1'b0, 1'b1);
    run(2, 5'b00001, 20'h00006, 1'b1);         // reset mid-packet
    drive(5'b00001, 20'h0, 1'b0, 1'b0, 1'b1);
    run(3, 5'b10001, 20'h0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      drive(5'($urandom), 20'($urandom) & 20'h33333, 1'($urandom % 2),
            ($urandom % 150) != 0, 1'b1);
    end
    run(3, 5'b00000, 20'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("status_drained", status_q.size(), 0);
    check("grants_drained", grant_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
